sdrc_wb_traffic_gen: RTL and testbench
======================================

# sdrc_wb_traffic_gen

Synthesizable, parametrised Wishbone master that exercises `sdrc_top` with a write-then-read-back burst pattern and self-checks returned data. It sits on the Wishbone side of the SDRAM controller, replacing bench-driven stimulus so the same traffic runs in simulation and on FPGA. Width, maximum burst length and pattern mode are generic. It reports the error count and the first failing address.

## Interface
- `APP_AW`, 26, Wishbone byte-address width
- `WB_DW`, 32, Wishbone data width (32 or 64)
- `MAX_BL`, 8, maximum beats per burst (power of 2)
- `CNT_W`, 16, width of burst and error counters
- `sys_clk`  in  1  single clock for all logic
- `resetn`  in  1  synchronous, active-low reset
- `start`  in  1  run request, sampled at a rising edge
- `cfg_base_addr`  in  APP_AW  first byte address, beat-aligned
- `cfg_num_bursts`  in  CNT_W  bursts per phase
- `cfg_burst_len`  in  $clog2(MAX_BL)+1  beats per burst
- `cfg_mode`  in  2  data pattern: 00 increment, 01 address-as-data, 10 LFSR, 11 walking-one
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone controls
- `wb_addr_o`  out  APP_AW  byte address
- `wb_dat_o`  out  WB_DW  write data
- `wb_sel_o`  out  WB_DW/8  byte enables, all ones
- `wb_cti_o`  out  3  010 for an incrementing burst, 111 for the last beat
- `wb_ack_i`  in  1  beat acknowledge
- `wb_dat_i`  in  WB_DW  read data
- `busy`  out  1  run in progress
- `done`  out  1  run complete; holds until the next accepted `start`
- `err_cnt`  out  CNT_W  mismatching beats, saturating
- `first_err_addr`  out  APP_AW  address of the first mismatch

## Operation
- FSM states:
  - IDLE: `start` → LOAD.
  - LOAD: latch the config, seed the generator → WR.
  - WR: write beats; when the last beat is acked, go to GAP.
  - GAP: 1 cycle with `cyc`=0. Go to WR if write bursts remain. Otherwise reseed the generator and reset the address → RD.
  - RD: read beats; at burst end go to RGAP.
  - RGAP: go to RD if read bursts remain, else → FLUSH.
  - FLUSH: 1 cycle to drain the compare register → DONE.
  - DONE: `start` → LOAD.
- Address advances by WB_DW/8 per acked beat and wraps modulo 2^APP_AW.
- Pattern generator advances one step per acked beat.
  - Increment: 0, 1, 2, …
  - Address-as-data: the byte address, zero-extended.
  - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, seed 32'h1; replicated for WB_DW=64.
  - Walking-one: a single 1 rotating left from bit 0.
- Read phase regenerates the identical sequence. Each read ack registers `wb_dat_i` and the expected value. A mismatch increments `err_cnt` one cycle later. The first mismatch also captures `first_err_addr`.
- Boundaries:
  - `cfg_burst_len`=0 is treated as 1; values above MAX_BL clamp to MAX_BL.
  - `cfg_num_bursts`=0 goes LOAD → DONE with no bus cycles and `err_cnt`=0.
  - `err_cnt` saturates at all ones.
  - `start` is ignored while `busy`. `start` in DONE clears `done`, `err_cnt` and `first_err_addr`.
  - `resetn` low mid-burst: `cyc`/`stb` drop at that edge and the FSM goes to IDLE. No beat completes.
- Reset values: all outputs 0, except `wb_sel_o` = all ones and `wb_cti_o` = 000.

## Timing
- `start` high at edge N: LOAD at N+1; `cyc`/`stb` high from N+2.
- Each beat holds address, data and `we` until `wb_ack_i` is sampled high. The next beat is presented the following cycle, so ack held high gives 1 beat per cycle.
- `wb_cti_o`=111 accompanies exactly the final beat of each burst.
- `busy` is high from LOAD through FLUSH.
- `done` rises 2 cycles after the final read ack; the final `err_cnt` is valid in that same cycle.

## Structure
- Package `sdrc_tg_pkg`:
  - state enum
  - `cfg_mode` enum
  - CTI constants (CTI_INCR=3'b010, CTI_EOB=3'b111)
  - LFSR polynomial and seed
- Sub-module `sdrc_tg_pattern_gen`: ports for seed/load, advance, mode and address in, data out. One instance serves both phases.

## Test plan
- Mode 00, base 0, 4 bursts × 8 beats, ack tied high, ideal memory → 32 writes of data 0..31, then 32 reads; `err_cnt`=0; `done` 2 cycles after the last ack.
- Mode 01 against `sdrc_top` + SDRAM model, base 26'h100, 2×4 beats → write data equals addresses 0x100..0x11C; read-back `err_cnt`=0.
- Ideal memory with bit 3 forced at address 0x10, mode 00 → `err_cnt`=1, `first_err_addr`=0x10.
- `cfg_burst_len`=0, `cfg_num_bursts`=3 → three single beats, each with `cti`=111 and `cyc` low between them. `cfg_num_bursts`=0 → `done` with no `cyc`.
- Base 26'h3FFFFF8, 1×4 beats → addresses 3FFFFF8, 3FFFFFC, 0000000, 0000004.
- `resetn` low during the 3rd beat with ack stalled → `cyc`/`stb` 0 at the next edge, all outputs at reset values; a new `start` then runs cleanly.

Source files
------------

// File: rtl/sdrc_wb_traffic_gen_pkg.sv
// Shared types and constants for the SDRAM Wishbone traffic generator.
package sdrc_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WR,
    ST_GAP,
    ST_RD,
    ST_RGAP,
    ST_FLUSH,
    ST_DONE
  } tg_state_e;

  typedef enum logic [1:0] {
    MODE_INCR = 2'b00,
    MODE_ADDR = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_WALK = 2'b11
  } tg_mode_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdrc_wb_traffic_gen_pattern_gen.sv
// Data pattern generator: one step per acked beat, reseeded per phase so
// the read phase regenerates exactly what was written.
module sdrc_tg_pattern_gen
  import sdrc_tg_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int WB_DW  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              advance,
  input  tg_mode_e          mode,
  input  logic [APP_AW-1:0] addr,
  output logic [WB_DW-1:0]  data
);

  logic [WB_DW-1:0] cnt;
  logic [WB_DW-1:0] walk;
  logic [31:0]      lfsr;

  // All generators step together; load restores the phase-start state
  always_ff @(posedge clk) begin
    if (!resetn || load) begin
      cnt  <= '0;
      walk <= WB_DW'(1);
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      cnt  <= cnt + WB_DW'(1);
      walk <= {walk[WB_DW-2:0], walk[WB_DW-1]};
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Select the pattern for the current beat
  always_comb begin
    data = '0;
    case (mode)
      MODE_INCR: data = cnt;
      MODE_ADDR: data = WB_DW'(addr);
      MODE_LFSR: data = {(WB_DW/32){lfsr}};
      MODE_WALK: data = walk;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/sdrc_wb_traffic_gen.sv
// Wishbone burst master: writes a pattern, reads it back and counts mismatches.
module sdrc_wb_traffic_gen
  import sdrc_tg_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int WB_DW  = 32,
  parameter int MAX_BL = 8,
  parameter int CNT_W  = 16
) (
  input  logic                      sys_clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [APP_AW-1:0]         cfg_base_addr,
  input  logic [CNT_W-1:0]          cfg_num_bursts,
  input  logic [$clog2(MAX_BL):0]   cfg_burst_len,
  input  logic [1:0]                cfg_mode,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [APP_AW-1:0]         wb_addr_o,
  output logic [WB_DW-1:0]          wb_dat_o,
  output logic [WB_DW/8-1:0]        wb_sel_o,
  output logic [2:0]                wb_cti_o,
  input  logic                      wb_ack_i,
  input  logic [WB_DW-1:0]          wb_dat_i,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [APP_AW-1:0]         first_err_addr
);

  localparam int BLW = $clog2(MAX_BL) + 1;
  localparam logic [APP_AW-1:0] STEP = APP_AW'(WB_DW / 8);

  tg_state_e         state, nxt;
  logic [APP_AW-1:0] base_q, addr_q;
  logic [CNT_W-1:0]  nb_q, left_q;
  logic [BLW-1:0]    bl_q, beat_q, bl_eff;
  tg_mode_e          mode_q;
  logic [WB_DW-1:0]  gen_data;
  logic              in_bus, beat_ack, last_beat, burst_end, start_ok, gen_load;
  logic              cmp_vld;
  logic [WB_DW-1:0]  cmp_got, cmp_exp;
  logic [APP_AW-1:0] cmp_addr;
  logic [CNT_W-1:0]  err_q;
  logic [APP_AW-1:0] ferr_q;

  assign bl_eff    = (cfg_burst_len == '0) ? BLW'(1) :
                     (cfg_burst_len > BLW'(MAX_BL)) ? BLW'(MAX_BL) : cfg_burst_len;
  assign in_bus    = (state == ST_WR) || (state == ST_RD);
  assign beat_ack  = in_bus && wb_ack_i;
  assign last_beat = (beat_q == bl_q - BLW'(1));
  assign burst_end = beat_ack && last_beat;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  // Seed at run start and again when the write phase hands over to reads
  assign gen_load  = (state == ST_LOAD) || ((state == ST_GAP) && (left_q == '0));

  assign wb_addr_o      = addr_q;
  assign wb_sel_o       = '1;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

  sdrc_tg_pattern_gen #(.APP_AW(APP_AW), .WB_DW(WB_DW)) u_pat (
    .clk     (sys_clk),
    .resetn  (resetn),
    .load    (gen_load),
    .advance (beat_ack),
    .mode    (mode_q),
    .addr    (addr_q),
    .data    (gen_data)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= nxt;
  end

  // Next state and bus/status outputs
  always_comb begin
    nxt      = state;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_cti_o = CTI_CLASSIC;
    wb_dat_o = '0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) nxt = ST_LOAD;
      end
      ST_LOAD:  nxt = (cfg_num_bursts == '0) ? ST_DONE : ST_WR;
      ST_WR: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
        wb_dat_o = gen_data;
        if (burst_end) nxt = ST_GAP;
      end
      ST_GAP:   nxt = (left_q != '0) ? ST_WR : ST_RD;
      ST_RD: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
        if (burst_end) nxt = ST_RGAP;
      end
      ST_RGAP:  nxt = (left_q != '0) ? ST_RD : ST_FLUSH;
      ST_FLUSH: nxt = ST_DONE;
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) nxt = ST_LOAD;
      end
      default: begin
        busy = 1'b0;
        nxt  = ST_IDLE;
      end
    endcase
  end

  // Config latch, address, beat and burst counters
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      base_q <= '0;
      nb_q   <= '0;
      bl_q   <= BLW'(1);
      mode_q <= MODE_INCR;
      addr_q <= '0;
      left_q <= '0;
      beat_q <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          base_q <= cfg_base_addr;
          nb_q   <= cfg_num_bursts;
          bl_q   <= bl_eff;
          mode_q <= tg_mode_e'(cfg_mode);
          addr_q <= cfg_base_addr;
          left_q <= cfg_num_bursts;
          beat_q <= '0;
        end
        ST_GAP: begin
          if (left_q == '0) begin
            addr_q <= base_q;
            left_q <= nb_q;
          end
        end
        default: ;
      endcase
      if (beat_ack) begin
        addr_q <= addr_q + STEP;
        beat_q <= last_beat ? '0 : beat_q + BLW'(1);
        if (last_beat) left_q <= left_q - CNT_W'(1);
      end
    end
  end

  // Read-back compare: register on ack, score one cycle later
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      cmp_vld  <= 1'b0;
      cmp_got  <= '0;
      cmp_exp  <= '0;
      cmp_addr <= '0;
      err_q    <= '0;
      ferr_q   <= '0;
    end else begin
      cmp_vld <= beat_ack && (state == ST_RD);
      if (beat_ack && (state == ST_RD)) begin
        cmp_got  <= wb_dat_i;
        cmp_exp  <= gen_data;
        cmp_addr <= addr_q;
      end
      if (start_ok) begin
        err_q  <= '0;
        ferr_q <= '0;
      end else if (cmp_vld && (cmp_got != cmp_exp)) begin
        if (err_q != '1)  err_q  <= err_q + CNT_W'(1);
        if (err_q == '0)  ferr_q <= cmp_addr;
      end
    end
  end

endmodule

// File: tb/tb_sdrc_wb_traffic_gen.sv
// Randomised bench: ideal Wishbone memory plus a beat-list model of the run.
module tb_sdrc_wb_traffic_gen;
  localparam int APP_AW = 26, WB_DW = 32, MAX_BL = 8, CNT_W = 8;
  localparam int BLW = $clog2(MAX_BL) + 1;

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [31:0] data;
    logic [2:0]  cti;
  } beat_t;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [APP_AW-1:0] cfg_base_addr = '0;
  logic [CNT_W-1:0]  cfg_num_bursts = '0;
  logic [BLW-1:0]    cfg_burst_len = '0;
  logic [1:0]        cfg_mode = '0;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [APP_AW-1:0]  wb_addr_o;
  logic [WB_DW-1:0]   wb_dat_o;
  logic [WB_DW/8-1:0] wb_sel_o;
  logic [2:0]         wb_cti_o;
  logic               wb_ack_i = 1'b0;
  logic [WB_DW-1:0]   wb_dat_i = '0;
  logic busy, done;
  logic [CNT_W-1:0]  err_cnt;
  logic [APP_AW-1:0] first_err_addr;

  always #5 clk = ~clk;

  sdrc_wb_traffic_gen #(.APP_AW(APP_AW), .WB_DW(WB_DW), .MAX_BL(MAX_BL), .CNT_W(CNT_W)) dut (
    .sys_clk(clk), .resetn(resetn), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts),
    .cfg_burst_len(cfg_burst_len), .cfg_mode(cfg_mode),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference pattern: value of beat idx (within a phase) at byte address a
  function automatic logic [31:0] pat(input int mode, input int idx, input logic [25:0] a);
    logic [31:0] l;
    case (mode)
      0: return 32'(idx);
      1: return {6'b0, a};
      2: begin
        l = 32'h1;
        repeat (idx) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        return l;
      end
      default: return 32'h1 << (idx % 32);
    endcase
  endfunction

  beat_t       q[$];
  logic [31:0] mem [logic [25:0]];
  logic [25:0] wr_addr_log[$];
  logic [31:0] wr_dat_log[$];
  int          exp_err, cyc_n = 0, last_rd_ack, exp_cyc_next = 2;
  int          ack_pct = 100, ack_budget = -1;
  bit          err_seen, had_rd, done_seen, fault_en, fault_all;
  logic [25:0] exp_first, fault_addr;
  logic        done_prev = 1'b0;

  // Slave + checker: compare every presented beat to the model, then answer it
  always @(negedge clk) begin
    beat_t b;
    logic [31:0] rd;
    cyc_n++;
    wb_ack_i = 1'b0;
    wb_dat_i = $urandom;
    if (resetn) begin
      chk("sel", wb_sel_o, 4'hf);
      if (exp_cyc_next != 2) chk("cyc_continuity", wb_cyc_o, exp_cyc_next[0]);
      exp_cyc_next = 2;
      if (wb_cyc_o) begin
        if (q.size() == 0) chk("stray_cyc", wb_cyc_o, 0);
        else begin
          b = q[0];
          chk("stb", wb_stb_o, 1);
          chk("we", wb_we_o, b.we);
          chk("addr", wb_addr_o, b.addr);
          chk("cti", wb_cti_o, b.cti);
          if (b.we) chk("wdata", wb_dat_o, b.data);
          if (ack_budget != 0 && $urandom_range(99) < ack_pct) begin
            wb_ack_i = 1'b1;
            if (ack_budget > 0) ack_budget--;
            if (b.we) begin
              mem[wb_addr_o] = wb_dat_o;
              wr_addr_log.push_back(wb_addr_o);
              wr_dat_log.push_back(wb_dat_o);
            end else begin
              rd = mem.exists(wb_addr_o) ? mem[wb_addr_o] : 32'h0;
              if (fault_all || (fault_en && wb_addr_o == fault_addr)) rd = rd ^ 32'h8;
              wb_dat_i = rd;
              if (rd != b.data) begin
                if (exp_err < (1 << CNT_W) - 1) exp_err++;
                if (!err_seen) begin err_seen = 1; exp_first = b.addr; end
              end
              last_rd_ack = cyc_n;
              had_rd = 1;
            end
            exp_cyc_next = (b.cti == 3'b111) ? 0 : 1;
            void'(q.pop_front());
          end
        end
      end
      if (done && !done_prev) begin
        chk("err_cnt", err_cnt, exp_err);
        chk("first_err_addr", first_err_addr, exp_first);
        chk("busy_at_done", busy, 0);
        chk("beats_left", q.size(), 0);
        if (had_rd) chk("done_latency", cyc_n - last_rd_ack, 3);
        done_seen = 1;
      end
    end
    done_prev = done;
  end

  task automatic build(input logic [25:0] base, input int nb, input int bl, input int mode,
                       input bit with_reads);
    int ebl;
    logic [25:0] a;
    beat_t b;
    ebl = (bl == 0) ? 1 : (bl > MAX_BL ? MAX_BL : bl);
    q.delete(); mem.delete(); wr_addr_log.delete(); wr_dat_log.delete();
    for (int ph = 0; ph < (with_reads ? 2 : 1); ph++) begin
      a = base;
      for (int i = 0; i < nb * ebl; i++) begin
        b.we = (ph == 0); b.addr = a; b.data = pat(mode, i, a);
        b.cti = ((i % ebl) == ebl - 1) ? 3'b111 : 3'b010;
        q.push_back(b);
        a = a + 26'd4;
      end
    end
    exp_err = 0; err_seen = 0; exp_first = '0; had_rd = 0; done_seen = 0;
  endtask

  task automatic kick(input logic [25:0] base, input int nb, input int bl, input int mode);
    @(negedge clk);
    cfg_base_addr = base; cfg_num_bursts = CNT_W'(nb);
    cfg_burst_len = BLW'(bl); cfg_mode = 2'(mode); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_load", busy, 1);
    chk("done_cleared", done, 0);
    chk("cyc_in_load", wb_cyc_o, 0);
    chk("err_cleared", err_cnt, 0);
    chk("ferr_cleared", first_err_addr, 0);
  endtask

  task automatic run(input logic [25:0] base, input int nb, input int bl, input int mode,
                     input int pct, input bit fen, input logic [25:0] faddr, input bit fall);
    build(base, nb, bl, mode, 1);
    ack_pct = pct; fault_en = fen; fault_addr = faddr; fault_all = fall;
    kick(base, nb, bl, mode);
    for (int t = 0; t < 20000 && !done_seen; t++) @(posedge clk);
    if (!done_seen) chk("done_timeout", done, 1);
  endtask

  logic [25:0] wrap_exp [4];
  logic [25:0] rb;

  initial begin
    wrap_exp = '{26'h3FFFFF8, 26'h3FFFFFC, 26'h0000000, 26'h0000004};

    // Pin the reference pattern to hand-computed values
    chk("pat_inc", pat(0, 7, 26'h0), 32'd7);
    chk("pat_addr", pat(1, 0, 26'h104), 32'h104);
    chk("pat_lfsr1", pat(2, 1, 26'h0), 32'h8020_0003);
    chk("pat_lfsr2", pat(2, 2, 26'h0), 32'hC030_0002);
    chk("pat_walk", pat(3, 33, 26'h0), 32'h2);

    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);   chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);     chk("rst_addr", wb_addr_o, 0);
    chk("rst_dat", wb_dat_o, 0);   chk("rst_sel", wb_sel_o, 4'hf);
    chk("rst_cti", wb_cti_o, 0);   chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);      chk("rst_err", err_cnt, 0);
    chk("rst_ferr", first_err_addr, 0);
    resetn = 1'b1;

    // Incrementing data, 4x8, ack tied high
    run(26'h0, 4, 8, 0, 100, 0, 26'h0, 0);
    chk("inc_count", wr_dat_log.size(), 32);
    for (int i = 0; i < 32; i++) chk("inc_data", wr_dat_log[i], 32'(i));

    // Address-as-data, 2x4 from 0x100
    run(26'h100, 2, 4, 1, 100, 0, 26'h0, 0);
    chk("addr_count", wr_dat_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("addr_data", wr_dat_log[i], 32'h100 + 32'(4 * i));

    // Corrupted read at 0x10
    run(26'h0, 4, 8, 0, 100, 1, 26'h10, 0);
    chk("fault_err", err_cnt, 1);
    chk("fault_addr", first_err_addr, 26'h10);

    // Burst length 0 means single beats
    run(26'h40, 3, 0, 3, 100, 0, 26'h0, 0);
    chk("single_count", wr_dat_log.size(), 3);

    // No bursts: straight to done
    run(26'h40, 0, 4, 0, 100, 0, 26'h0, 0);
    chk("empty_count", wr_dat_log.size(), 0);
    chk("empty_done", done, 1);

    // Address wrap at the top of the space
    run(26'h3FFFFF8, 1, 4, 2, 100, 0, 26'h0, 0);
    chk("wrap_count", wr_addr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("wrap_addr", wr_addr_log[i], wrap_exp[i]);

    // Every read corrupted: counter must saturate
    run(26'h0, 40, 8, 2, 100, 0, 26'h0, 1);
    chk("err_saturated", err_cnt, 8'hff);
    fault_all = 0;

    // Random configs with random ack stalls and an occasional fault
    for (int r = 0; r < 6; r++) begin
      rb = 26'($urandom) & ~26'd3;
      run(rb, $urandom_range(1, 5), $urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(40, 100), 1'($urandom_range(0, 1)),
          rb + 26'(4 * $urandom_range(0, 7)), 0);
    end

    // Reset while the third beat is stalled
    build(26'h0, 1, 8, 0, 1);
    ack_pct = 100; ack_budget = 2;
    kick(26'h0, 1, 8, 0);
    repeat (4) @(negedge clk);
    chk("stall_cyc", wb_cyc_o, 1);
    chk("stall_addr", wb_addr_o, 26'h8);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_cyc", wb_cyc_o, 0);  chk("mid_rst_stb", wb_stb_o, 0);
    chk("mid_rst_we", wb_we_o, 0);    chk("mid_rst_addr", wb_addr_o, 0);
    chk("mid_rst_dat", wb_dat_o, 0);  chk("mid_rst_cti", wb_cti_o, 0);
    chk("mid_rst_busy", busy, 0);     chk("mid_rst_done", done, 0);
    #1 resetn = 1'b1;
    q.delete(); ack_budget = -1; exp_cyc_next = 2;
    run(26'h200, 2, 4, 1, 70, 0, 26'h0, 0);
    chk("post_rst_count", wr_dat_log.size(), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
